// File: rtl/uc_dispatch.sv
// Unit-clause dispatcher: pops literals from the UC queue, dedups them against an assignment table, forwards new ones to the engine.
// Latency: pop in cycle N, eng_valid in cycle N+2; at most one literal every 3 cycles.
// Backpressure: holds eng_valid/eng_lit until eng_ready; no pops while a literal is in flight or after a conflict (HALT).
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   ucq_empty       : UC queue empty flag
//   ucq2eng         : UC queue head (first-word fall-through)
//   ucq_pop         : one-cycle pop strobe to the UC queue
//   clear           : flush of assignment table and conflict state
//   eng_valid/lit   : literal offered to the engine
//   eng_ready       : engine accepts the offered literal
//   conflict/_lit   : sticky conflict flag and the literal that caused it
//   dup_cnt         : saturating count of dropped duplicates
//   busy            : FSM in CHECK or ISSUE
module uc_dispatch #(
  parameter int UC_LENGTH = 512,
  parameter int NUM_VARS  = UC_LENGTH / 2,
  localparam int LIT_W    = $clog2(UC_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ucq_empty,
  input  logic [LIT_W-1:0] ucq2eng,
  output logic             ucq_pop,
  input  logic             clear,
  output logic             eng_valid,
  output logic [LIT_W-1:0] eng_lit,
  input  logic             eng_ready,
  output logic             conflict,
  output logic [LIT_W-1:0] conflict_lit,
  output logic [15:0]      dup_cnt,
  output logic             busy
);

  localparam int VAR_W = LIT_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LIT_W-1:0]    r_lit;
  logic [NUM_VARS-1:0] r_asg;
  logic [NUM_VARS-1:0] r_neg;
  logic                r_eng_valid;
  logic [LIT_W-1:0]    r_eng_lit;
  logic                r_conflict;
  logic [LIT_W-1:0]    r_conflict_lit;
  logic [15:0]         r_dup_cnt;

  logic [VAR_W-1:0]    w_var;
  logic                w_in_range;
  logic                w_pop;
  logic                w_set;
  logic                w_dup;
  logic                w_conf;
  logic                w_accept;

  assign w_var      = r_lit[LIT_W-1:1];
  // Variables beyond the table are folded into the duplicate path.
  assign w_in_range = ({1'b0, w_var} < (VAR_W + 1)'(NUM_VARS));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_set       = 1'b0;
    w_dup       = 1'b0;
    w_conf      = 1'b0;
    w_accept    = 1'b0;
    if (clear) begin
      // Flush wins over everything, including a literal in CHECK/ISSUE.
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!ucq_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!w_in_range || (r_asg[w_var] && (r_neg[w_var] == r_lit[0]))) begin
            w_dup       = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_asg[w_var]) begin
            w_conf      = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_set       = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_ready) begin
            w_accept    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_HALT: begin
          w_state_nxt = S_HALT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_lit          <= '0;
      r_asg          <= '0;
      r_neg          <= '0;
      r_eng_valid    <= 1'b0;
      r_eng_lit      <= '0;
      r_conflict     <= 1'b0;
      r_conflict_lit <= '0;
      r_dup_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_asg          <= '0;
        r_neg          <= '0;
        r_eng_valid    <= 1'b0;
        r_conflict     <= 1'b0;
        r_conflict_lit <= '0;
      end else begin
        if (w_pop) begin
          r_lit <= ucq2eng;
        end
        if (w_set) begin
          r_asg[w_var] <= 1'b1;
          r_neg[w_var] <= r_lit[0];
          r_eng_valid  <= 1'b1;
          r_eng_lit    <= r_lit;
        end else if (w_accept) begin
          r_eng_valid <= 1'b0;
        end
        if (w_dup && (r_dup_cnt != 16'hFFFF)) begin
          r_dup_cnt <= r_dup_cnt + 16'd1;
        end
        if (w_conf) begin
          r_conflict     <= 1'b1;
          r_conflict_lit <= r_lit;
        end
      end
    end
  end

  // Gated with rst so nothing is consumed from the queue while in reset.
  assign ucq_pop      = w_pop & rst;
  assign eng_valid    = r_eng_valid;
  assign eng_lit      = r_eng_lit;
  assign conflict     = r_conflict;
  assign conflict_lit = r_conflict_lit;
  assign dup_cnt      = r_dup_cnt;
  assign busy         = (r_state == S_CHECK) || (r_state == S_ISSUE);

endmodule

// File: tb/tb_uc_dispatch.sv
// Testbench for uc_dispatch: directed scenarios plus randomized traffic against a literal-level model.
// Inputs driven just after the falling edge, outputs sampled 1-2 time units later.
// Queue model pops on every edge where ucq_pop was high just before that edge.
module tb_uc_dispatch;

  localparam int NUM_VARS = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       ucq_empty;
  logic [8:0] ucq2eng;
  logic       ucq_pop;
  logic       clear;
  logic       eng_valid;
  logic [8:0] eng_lit;
  logic       eng_ready;
  logic       conflict;
  logic [8:0] conflict_lit;
  logic [15:0] dup_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // UC queue contents and reference model state
  logic [8:0] q[$];
  logic [8:0] exp_issue[$];
  bit         m_asg[NUM_VARS];
  bit         m_neg[NUM_VARS];
  int         m_dup = 0;
  bit         m_conf = 0;
  logic [8:0] m_conf_lit = '0;
  logic       pop_seen, rst_seen, clr_seen;

  uc_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .ucq_empty    (ucq_empty),
    .ucq2eng      (ucq2eng),
    .ucq_pop      (ucq_pop),
    .clear        (clear),
    .eng_valid    (eng_valid),
    .eng_lit      (eng_lit),
    .eng_ready    (eng_ready),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .dup_cnt      (dup_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic refresh_q();
    ucq_empty = (q.size() == 0);
    ucq2eng   = (q.size() != 0) ? q[0] : 9'd0;
  endtask

  task automatic push_lit(input logic [8:0] lit);
    q.push_back(lit);
    refresh_q();
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NUM_VARS; i++) begin
      m_asg[i] = 1'b0;
      m_neg[i] = 1'b0;
    end
    exp_issue.delete();
    m_conf     = 1'b0;
    m_conf_lit = '0;
  endfunction

  // Outcome of one popped literal, decided from the dispatch rules directly.
  function automatic void model_pop(input logic [8:0] lit);
    int v;
    v = int'(lit[8:1]);
    if (v >= NUM_VARS || (m_asg[v] && m_neg[v] == lit[0])) begin
      if (m_dup < 65535) m_dup++;
    end else if (!m_asg[v]) begin
      m_asg[v] = 1'b1;
      m_neg[v] = lit[0];
      exp_issue.push_back(lit);
    end else begin
      m_conf     = 1'b1;
      m_conf_lit = lit;
    end
  endfunction

  // Queue/model driver: sample strobes just before each rising edge, apply just after.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      pop_seen = ucq_pop;
      rst_seen = rst;
      clr_seen = clear;
      @(posedge clk);
      #1;
      if (rst_seen !== 1'b1) begin
        model_clear();
        m_dup = 0;
      end else if (clr_seen === 1'b1) begin
        model_clear();
      end else if (pop_seen === 1'b1 && q.size() != 0) begin
        model_pop(q.pop_front());
      end
      refresh_q();
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    nxt();
    nxt();
    checks++; if (ucq_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", ucq_pop); end
    checks++; if (eng_valid !== 1'b0) begin errors++; $display("FAIL reset_eng_valid: got %b want 0", eng_valid); end
    checks++; if (eng_lit !== 9'd0) begin errors++; $display("FAIL reset_eng_lit: got %0d want 0", eng_lit); end
    checks++; if (conflict !== 1'b0 || conflict_lit !== 9'd0) begin errors++; $display("FAIL reset_conflict: got %b/%0d want 0/0", conflict, conflict_lit); end
    checks++; if (dup_cnt !== 16'd0) begin errors++; $display("FAIL reset_dup_cnt: got %0d want 0", dup_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    // Queue becomes non-empty while still in reset: no pop allowed.
    push_lit(9'd4);
    #1;
    checks++; if (ucq_pop !== 1'b0) begin errors++; $display("FAIL reset_no_pop: got %b want 0", ucq_pop); end
  endtask

  task automatic test_single();
    nxt();
    rst = 1'b1;
    eng_ready = 1'b1;
    #1;
    checks++; if (ucq_pop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_pop: pop/busy got %b/%b want 1/0", ucq_pop, busy); end
    nxt();
    checks++; if (ucq_pop !== 1'b0 || eng_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_check: pop/valid/busy got %b/%b/%b want 0/0/1", ucq_pop, eng_valid, busy); end
    nxt();
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd4) begin errors++; $display("FAIL single_issue: valid/lit got %b/%0d want 1/4", eng_valid, eng_lit); end
    nxt();
    checks++; if (eng_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: valid/busy got %b/%b want 0/0", eng_valid, busy); end
  endtask

  task automatic test_dup();
    push_lit(9'd4);
    #1;
    checks++; if (ucq_pop !== 1'b1) begin errors++; $display("FAIL dup_pop: got %b want 1", ucq_pop); end
    nxt();
    checks++; if (eng_valid !== 1'b0) begin errors++; $display("FAIL dup_check_valid: got %b want 0", eng_valid); end
    nxt();
    checks++; if (eng_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dup_idle: valid/busy got %b/%b want 0/0", eng_valid, busy); end
    checks++; if (dup_cnt !== 16'd1) begin errors++; $display("FAIL dup_cnt: got %0d want 1", dup_cnt); end
  endtask

  task automatic test_conflict();
    push_lit(9'd5);
    #1;
    checks++; if (ucq_pop !== 1'b1) begin errors++; $display("FAIL conf_pop: got %b want 1", ucq_pop); end
    nxt();
    nxt();
    checks++; if (conflict !== 1'b1 || conflict_lit !== 9'd5) begin errors++; $display("FAIL conf_flag: got %b/%0d want 1/5", conflict, conflict_lit); end
    checks++; if (busy !== 1'b0 || eng_valid !== 1'b0) begin errors++; $display("FAIL conf_halt: busy/valid got %b/%b want 0/0", busy, eng_valid); end
    push_lit(9'd5);
    for (int i = 0; i < 3; i++) begin
      nxt();
      checks++; if (ucq_pop !== 1'b0 || ucq_empty !== 1'b0 || conflict !== 1'b1) begin errors++; $display("FAIL conf_hold: pop/empty/conflict got %b/%b/%b want 0/0/1", ucq_pop, ucq_empty, conflict); end
    end
  endtask

  task automatic test_clear();
    nxt();
    clear = 1'b1;
    #1;
    checks++; if (ucq_pop !== 1'b0) begin errors++; $display("FAIL clear_no_pop: got %b want 0", ucq_pop); end
    nxt();
    clear = 1'b0;
    #1;
    checks++; if (conflict !== 1'b0 || conflict_lit !== 9'd0) begin errors++; $display("FAIL clear_conflict: got %b/%0d want 0/0", conflict, conflict_lit); end
    checks++; if (busy !== 1'b0 || ucq_pop !== 1'b1) begin errors++; $display("FAIL clear_idle: busy/pop got %b/%b want 0/1", busy, ucq_pop); end
    nxt();
    nxt();
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd5) begin errors++; $display("FAIL clear_redispatch: valid/lit got %b/%0d want 1/5", eng_valid, eng_lit); end
    nxt();
  endtask

  task automatic test_stall();
    eng_ready = 1'b0;
    push_lit(9'd8);
    nxt();
    nxt();
    push_lit(9'd10);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) nxt();
      checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd8 || ucq_pop !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: valid/lit/pop got %b/%0d/%b want 1/8/0", i, eng_valid, eng_lit, ucq_pop); end
    end
    nxt();
    eng_ready = 1'b1;
    #1;
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd8) begin errors++; $display("FAIL stall_release: valid/lit got %b/%0d want 1/8", eng_valid, eng_lit); end
    nxt();
    checks++; if (eng_valid !== 1'b0 || busy !== 1'b0 || ucq_pop !== 1'b1) begin errors++; $display("FAIL stall_idle: valid/busy/pop got %b/%b/%b want 0/0/1", eng_valid, busy, ucq_pop); end
    nxt();
    nxt();
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd10) begin errors++; $display("FAIL stall_next: valid/lit got %b/%0d want 1/10", eng_valid, eng_lit); end
    nxt();
  endtask

  task automatic test_reset_issue();
    eng_ready = 1'b0;
    push_lit(9'd12);
    nxt();
    nxt();
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd12) begin errors++; $display("FAIL rstiss_issue: valid/lit got %b/%0d want 1/12", eng_valid, eng_lit); end
    rst = 1'b0;
    nxt();
    checks++; if (eng_valid !== 1'b0 || eng_lit !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstiss_reset: valid/lit/busy got %b/%0d/%b want 0/0/0", eng_valid, eng_lit, busy); end
    checks++; if (dup_cnt !== 16'd0) begin errors++; $display("FAIL rstiss_dup: got %0d want 0", dup_cnt); end
    push_lit(9'd12);
    #1;
    checks++; if (ucq_pop !== 1'b0) begin errors++; $display("FAIL rstiss_no_pop: got %b want 0", ucq_pop); end
    nxt();
    rst = 1'b1;
    eng_ready = 1'b1;
    #1;
    checks++; if (ucq_pop !== 1'b1) begin errors++; $display("FAIL rstiss_pop: got %b want 1", ucq_pop); end
    nxt();
    nxt();
    checks++; if (eng_valid !== 1'b1 || eng_lit !== 9'd12 || dup_cnt !== 16'd0) begin errors++; $display("FAIL rstiss_unassigned: valid/lit/dup got %b/%0d/%0d want 1/12/0", eng_valid, eng_lit, dup_cnt); end
    nxt();
  endtask

  task automatic test_random();
    int n_hs = 0;
    int n_conf = 0;
    logic [8:0] lit;
    logic [8:0] exp_lit;
    exp_issue.delete();
    for (int c = 0; c < 2000; c++) begin
      nxt();
      clear = 1'b0;
      eng_ready = ($urandom_range(0, 3) != 0);
      if (c < 1800 && q.size() < 2 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0) lit = 9'($urandom_range(0, 511));
        else lit = {4'd0, 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1))};
        push_lit(lit);
      end
      #1;
      if (conflict === 1'b1) begin
        n_conf++;
        checks++; if (m_conf !== 1'b1 || conflict_lit !== m_conf_lit) begin errors++; $display("FAIL rnd_conflict: flag/lit got 1/%0d want %b/%0d", conflict_lit, m_conf, m_conf_lit); end
        clear = 1'b1;
      end else if (eng_valid === 1'b1 && eng_ready === 1'b1) begin
        n_hs++;
        exp_lit = (exp_issue.size() != 0) ? exp_issue.pop_front() : 9'h1FF;
        checks++; if (eng_lit !== exp_lit) begin errors++; $display("FAIL rnd_issue: eng_lit got %0d want %0d", eng_lit, exp_lit); end
      end
    end
    nxt();
    clear = 1'b0;
    #1;
    checks++; if (dup_cnt !== 16'(m_dup)) begin errors++; $display("FAIL rnd_dup_cnt: got %0d want %0d", dup_cnt, m_dup); end
    checks++; if (exp_issue.size() != 0 || eng_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: pending %0d valid %b want 0/0", exp_issue.size(), eng_valid); end
    checks++; if (n_hs < 50 || n_conf < 3) begin errors++; $display("FAIL rnd_activity: handshakes %0d conflicts %0d want >=50/>=3", n_hs, n_conf); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    eng_ready = 1'b1;
    ucq_empty = 1'b1;
    ucq2eng   = 9'd0;
    test_reset();
    test_single();
    test_dup();
    test_conflict();
    test_clear();
    test_stall();
    test_reset_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
